wshb_sdram_arbiter: RTL and testbench
=====================================

# wshb_sdram_arbiter

Two-master Wishbone arbiter placed in front of the SDRAM slave port of `hw_support`. It shares the single `wshb_if_sdram` bus between the video-stream reader (master 0) and a pixel writer (master 1). Arbitration is round-robin, and a grant is held for a master's whole `cyc` cycle. The block has a 1-cycle grant latency and zero added latency on the data and acknowledge path. It is instantiated in `Top` on `sys_clk`/`sys_rst`.

## Interface
Parameters:
- `DATA_BYTES`, default 4. Byte width of all three `wshb_if` ports. Must match the connected interfaces.
- `FIRST_MASTER`, default 0. Which master wins the first simultaneous request after reset.

Ports:
- `sys_clk`  in  1  system clock (100 MHz). Single clock domain.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `wshb_ifs0`  `wshb_if.slave`  —  master 0 (video reader) connects here.
- `wshb_ifs1`  `wshb_if.slave`  —  master 1 (pixel writer) connects here.
- `wshb_ifm`  `wshb_if.master`  —  toward `hw_support.wshb_ifs` (SDRAM).
- `grant`  out  2  one-hot current owner; `2'b00` when idle. Used for debug LEDs.

## Operation
- FSM states are IDLE, GNT0 and GNT1. A register `last` holds the most recently granted master; on reset it is loaded with `1-FIRST_MASTER`.
- **IDLE**
  - Only `cyc0` high → GNT0. Only `cyc1` high → GNT1.
  - Both high → grant the master ≠ `last`.
  - Neither high → stay in IDLE.
- **GNTx**
  - Stay while `cycx`=1.
  - When `cycx`=0: go to GNTy if `cycy`=1 (no idle bubble), else go to IDLE.
- On every entry to GNTx, `last` ← x.
- **Downstream mux in GNTx:** `cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel`, `cti` and `bte` on `wshb_ifm` are combinational copies of master x.
- **Downstream in IDLE:** all of those outputs are 0.
- **Upstream to the granted master:** `ack`, `err`, `rty` and `dat_sm` are combinational from `wshb_ifm`.
- **Upstream to a non-granted master:** `ack`, `err` and `rty` are 0. `dat_sm` is still driven with `wshb_ifm.dat_sm`, which is harmless.
- A master's `stb` is never forwarded unless that master holds the grant. The non-granted master simply waits with `cyc`/`stb` asserted.
- No preemption. A master that keeps `cyc` high holds the bus indefinitely; fairness is guaranteed only at `cyc` boundaries.
- **Reset mid-transfer:** the state goes to IDLE on the next edge and downstream `cyc`/`stb` drop in that same cycle. The in-flight ack is lost, and the masters are reset by the same `sys_rst`.

## Timing
- Reset values:
  - state = IDLE, `grant` = `2'b00`.
  - All `wshb_ifm` outputs are 0.
  - All upstream `ack`/`err`/`rty` are 0.
- Grant latency: if `cycx` rises and is sampled at edge n with the FSM in IDLE, then GNTx becomes valid after edge n. Downstream `cyc`/`stb` are visible in cycle n+1, so there is 1 cycle of added latency.
- Inside a grant, downstream requests and upstream ack pass through combinationally with 0 cycles added. Pipelined and burst (`cti`/`bte`) transfers are therefore unaffected.
- Handover: master x drops `cyc` in cycle k while `cycy`=1. GNTy is active after edge k+1, giving exactly 1 cycle with downstream `cyc` from neither master.
- `grant` is a registered decode of the state and changes only on a clock edge.

## Structure
- Package `wshb_arb_pkg` holds:
  - typedef enum logic[1:0] `arb_state_t` {IDLE, GNT0, GNT1};
  - localparam `NB_MASTERS = 2`.
- Sub-module `wshb_arb_rr` is the round-robin next-owner picker. It is combinational.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `pick`, `valid`.
- The parent contains the FSM, `last`, `grant` and both muxes.

## Test plan
- **Reset:** hold `sys_rst`=1 for 3 cycles with `cyc0`=`cyc1`=1. Required: `grant`=00, `wshb_ifm.cyc`=0, `ack0`=`ack1`=0 throughout.
- **Single master:** master 0 issues a single read at `adr`=0x100; the slave acks after 2 wait states with data 0xDEADBEEF. Required:
  - `grant`=01 one cycle after `cyc0` is sampled;
  - master 0 reads 0xDEADBEEF;
  - `ack1` stays 0;
  - `grant`=00 after `cyc0` drops.
- **Simultaneous request:** both masters raise `cyc` in the same cycle right after reset with `FIRST_MASTER`=0. Required:
  - master 0 is granted first;
  - after `cyc0` falls, master 1 is granted after exactly 1 gap cycle;
  - a second simultaneous request then goes to master 0.
- **Burst hold:** master 1 runs an 8-beat incrementing burst (`cti`=010, ending with 111) while `cyc0` is held high. Required:
  - all 8 acks go to master 1;
  - `ack0`=0 throughout;
  - master 0 is granted only after `cyc1` drops.
- **Error passthrough:** the slave asserts `err` on master 0's write. Required: `err0`=1 in the same cycle and `err1`=0.
- **Mid-transfer reset:** assert `sys_rst` during GNT1 with `stb` pending. Required: next cycle `wshb_ifm.cyc`=0, `grant`=00; after release the arbitration order restarts from `FIRST_MASTER`.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;

    localparam int NB_MASTERS = 2;
    localparam int ADR_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wshb_arb_rr.sv
// Combinational round-robin picker: chooses the next owner among the requesters.
module wshb_arb_rr
    import wshb_arb_pkg::*;
(
    input  logic [NB_MASTERS-1:0] req,
    input  logic                  last,
    output logic                  pick,
    output logic                  valid
);

    always_comb begin
        valid = |req;
        // On contention the master that did not own the bus last time wins.
        if (req[0] && req[1]) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM slave port; the grant is held
// for a master's whole cyc cycle, and the data/ack path is purely combinational.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES   = 4,
    parameter int FIRST_MASTER = 0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,

    input  logic                      ifs0_cyc,
    input  logic                      ifs0_stb,
    input  logic                      ifs0_we,
    input  logic [ADR_W-1:0]          ifs0_adr,
    input  logic [8*DATA_BYTES-1:0]   ifs0_dat_ms,
    input  logic [DATA_BYTES-1:0]     ifs0_sel,
    input  logic [2:0]                ifs0_cti,
    input  logic [1:0]                ifs0_bte,
    output logic                      ifs0_ack,
    output logic                      ifs0_err,
    output logic                      ifs0_rty,
    output logic [8*DATA_BYTES-1:0]   ifs0_dat_sm,

    input  logic                      ifs1_cyc,
    input  logic                      ifs1_stb,
    input  logic                      ifs1_we,
    input  logic [ADR_W-1:0]          ifs1_adr,
    input  logic [8*DATA_BYTES-1:0]   ifs1_dat_ms,
    input  logic [DATA_BYTES-1:0]     ifs1_sel,
    input  logic [2:0]                ifs1_cti,
    input  logic [1:0]                ifs1_bte,
    output logic                      ifs1_ack,
    output logic                      ifs1_err,
    output logic                      ifs1_rty,
    output logic [8*DATA_BYTES-1:0]   ifs1_dat_sm,

    output logic                      ifm_cyc,
    output logic                      ifm_stb,
    output logic                      ifm_we,
    output logic [ADR_W-1:0]          ifm_adr,
    output logic [8*DATA_BYTES-1:0]   ifm_dat_ms,
    output logic [DATA_BYTES-1:0]     ifm_sel,
    output logic [2:0]                ifm_cti,
    output logic [1:0]                ifm_bte,
    input  logic                      ifm_ack,
    input  logic                      ifm_err,
    input  logic                      ifm_rty,
    input  logic [8*DATA_BYTES-1:0]   ifm_dat_sm,

    output logic [1:0]                grant
);

    arb_state_t            state_reg, state_next;
    logic                  last_reg;
    logic [1:0]            grant_reg;
    logic                  rr_pick, rr_valid;
    logic [NB_MASTERS-1:0] owner, up_ack, up_err, up_rty;

    wshb_arb_rr u_rr (
        .req   ({ifs1_cyc, ifs0_cyc}),
        .last  (last_reg),
        .pick  (rr_pick),
        .valid (rr_valid)
    );

    // A GNTx state moves straight to the other master when it is waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rr_valid) state_next = rr_pick ? GNT1 : GNT0;
            GNT0:    if (!ifs0_cyc) state_next = ifs1_cyc ? GNT1 : IDLE;
            GNT1:    if (!ifs1_cyc) state_next = ifs0_cyc ? GNT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
            last_reg  <= (FIRST_MASTER == 0) ? 1'b1 : 1'b0;
            grant_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            grant_reg <= {state_next == GNT1, state_next == GNT0};
            if (state_next == GNT0 && state_reg != GNT0) begin
                last_reg <= 1'b0;
            end else if (state_next == GNT1 && state_reg != GNT1) begin
                last_reg <= 1'b1;
            end
        end
    end

    assign grant = grant_reg;

    always_comb begin
        ifm_cyc    = 1'b0;
        ifm_stb    = 1'b0;
        ifm_we     = 1'b0;
        ifm_adr    = '0;
        ifm_dat_ms = '0;
        ifm_sel    = '0;
        ifm_cti    = '0;
        ifm_bte    = '0;
        case (state_reg)
            GNT0: begin
                ifm_cyc    = ifs0_cyc;
                ifm_stb    = ifs0_stb;
                ifm_we     = ifs0_we;
                ifm_adr    = ifs0_adr;
                ifm_dat_ms = ifs0_dat_ms;
                ifm_sel    = ifs0_sel;
                ifm_cti    = ifs0_cti;
                ifm_bte    = ifs0_bte;
            end
            GNT1: begin
                ifm_cyc    = ifs1_cyc;
                ifm_stb    = ifs1_stb;
                ifm_we     = ifs1_we;
                ifm_adr    = ifs1_adr;
                ifm_dat_ms = ifs1_dat_ms;
                ifm_sel    = ifs1_sel;
                ifm_cti    = ifs1_cti;
                ifm_bte    = ifs1_bte;
            end
            default: ;
        endcase
    end

    // Responses reach only the owner; read data fans out to both unconditionally.
    assign owner = {state_reg == GNT1, state_reg == GNT0};

    genvar gi;
    generate
        for (gi = 0; gi < NB_MASTERS; gi++) begin : g_up
            assign up_ack[gi] = owner[gi] & ifm_ack;
            assign up_err[gi] = owner[gi] & ifm_err;
            assign up_rty[gi] = owner[gi] & ifm_rty;
        end
    endgenerate

    assign ifs0_ack    = up_ack[0];
    assign ifs0_err    = up_err[0];
    assign ifs0_rty    = up_rty[0];
    assign ifs0_dat_sm = ifm_dat_sm;
    assign ifs1_ack    = up_ack[1];
    assign ifs1_err    = up_err[1];
    assign ifs1_rty    = up_rty[1];
    assign ifs1_dat_sm = ifm_dat_sm;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Scoreboard bench for wshb_sdram_arbiter: masters queue expected responses,
// a monitor pops and compares them whenever a master sees ack/err/rty.
module tb_wshb_sdram_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    logic        ifs0_cyc, ifs0_stb, ifs0_we, ifs0_ack, ifs0_err, ifs0_rty;
    logic [31:0] ifs0_adr, ifs0_dat_ms, ifs0_dat_sm;
    logic [3:0]  ifs0_sel;
    logic [2:0]  ifs0_cti;
    logic [1:0]  ifs0_bte;
    logic        ifs1_cyc, ifs1_stb, ifs1_we, ifs1_ack, ifs1_err, ifs1_rty;
    logic [31:0] ifs1_adr, ifs1_dat_ms, ifs1_dat_sm;
    logic [3:0]  ifs1_sel;
    logic [2:0]  ifs1_cti;
    logic [1:0]  ifs1_bte;
    logic        ifm_cyc, ifm_stb, ifm_we, ifm_ack, ifm_err, ifm_rty;
    logic [31:0] ifm_adr, ifm_dat_ms, ifm_dat_sm;
    logic [3:0]  ifm_sel;
    logic [2:0]  ifm_cti;
    logic [1:0]  ifm_bte;
    logic [1:0]  grant;

    wshb_sdram_arbiter #(.DATA_BYTES(4), .FIRST_MASTER(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .ifs0_cyc(ifs0_cyc), .ifs0_stb(ifs0_stb), .ifs0_we(ifs0_we), .ifs0_adr(ifs0_adr),
        .ifs0_dat_ms(ifs0_dat_ms), .ifs0_sel(ifs0_sel), .ifs0_cti(ifs0_cti), .ifs0_bte(ifs0_bte),
        .ifs0_ack(ifs0_ack), .ifs0_err(ifs0_err), .ifs0_rty(ifs0_rty), .ifs0_dat_sm(ifs0_dat_sm),
        .ifs1_cyc(ifs1_cyc), .ifs1_stb(ifs1_stb), .ifs1_we(ifs1_we), .ifs1_adr(ifs1_adr),
        .ifs1_dat_ms(ifs1_dat_ms), .ifs1_sel(ifs1_sel), .ifs1_cti(ifs1_cti), .ifs1_bte(ifs1_bte),
        .ifs1_ack(ifs1_ack), .ifs1_err(ifs1_err), .ifs1_rty(ifs1_rty), .ifs1_dat_sm(ifs1_dat_sm),
        .ifm_cyc(ifm_cyc), .ifm_stb(ifm_stb), .ifm_we(ifm_we), .ifm_adr(ifm_adr),
        .ifm_dat_ms(ifm_dat_ms), .ifm_sel(ifm_sel), .ifm_cti(ifm_cti), .ifm_bte(ifm_bte),
        .ifm_ack(ifm_ack), .ifm_err(ifm_err), .ifm_rty(ifm_rty), .ifm_dat_sm(ifm_dat_sm),
        .grant(grant)
    );

    // Slave model: registered ack after slv_wait extra cycles, data derived from address.
    int   slv_wait = 1;
    logic slv_err_en = 1'b0;
    logic slv_ack;
    int   wcnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slv_ack <= 1'b0;
            wcnt    <= 0;
        end else if (ifm_cyc && ifm_stb && !slv_ack) begin
            if (wcnt >= slv_wait) begin
                slv_ack <= 1'b1;
                wcnt    <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            slv_ack <= 1'b0;
            if (!(ifm_cyc && ifm_stb)) wcnt <= 0;
        end
    end

    assign ifm_ack    = slv_ack & ~slv_err_en;
    assign ifm_err    = slv_ack & slv_err_en;
    assign ifm_rty    = 1'b0;
    assign ifm_dat_sm = (ifm_adr == 32'h100) ? 32'hDEADBEEF : {16'hB000, ifm_adr[15:0]};

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_resp(input int m, input logic err, input logic [31:0] dat);
        exp_t e;
        logic empty;
        checks++;
        empty = (m == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            errors++;
            $display("FAIL m%0d_resp: got unexpected response err=%b data=0x%h, required none", m, err, dat);
        end else begin
            if (m == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (err !== e.err || (e.chk && dat !== e.data)) begin
                errors++;
                $display("FAIL m%0d_resp: got err=%b data=0x%h, required err=%b data=0x%h",
                         m, err, dat, e.err, e.data);
            end else begin
                $display("m%0d response ok: err=%b data=0x%h", m, err, dat);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (ifs0_ack || ifs0_err || ifs0_rty) check_resp(0, ifs0_err, ifs0_dat_sm);
            if (ifs1_ack || ifs1_err || ifs1_rty) check_resp(1, ifs1_err, ifs1_dat_sm);
        end
    end

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        if (m == 0) begin
            ifs0_cyc = cyc; ifs0_stb = stb; ifs0_we = we; ifs0_adr = adr;
            ifs0_dat_ms = dat; ifs0_sel = 4'hF; ifs0_cti = cti; ifs0_bte = 2'b00;
        end else begin
            ifs1_cyc = cyc; ifs1_stb = stb; ifs1_we = we; ifs1_adr = adr;
            ifs1_dat_ms = dat; ifs1_sel = 4'hF; ifs1_cti = cti; ifs1_bte = 2'b00;
        end
    endtask

    // One cyc cycle of 'beats' classic/incrementing-burst beats; read data expected at exp_base+4*beat.
    task automatic wb_xfer(input int m, input int beats, input logic we, input logic [31:0] adr,
                           input logic [31:0] wdat, input logic exp_err, input logic [31:0] exp_base);
        exp_t        e;
        logic [31:0] a;
        logic [2:0]  cti;
        logic        got;
        int          t;
        for (int b = 0; b < beats; b++) begin
            e.err  = exp_err;
            e.chk  = !we && !exp_err;
            e.data = exp_base + 32'(4 * b);
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        a = adr;
        @(posedge sys_clk); #1;
        for (int b = 0; b < beats; b++) begin
            if (beats == 1)          cti = 3'b000;
            else if (b == beats - 1) cti = 3'b111;
            else                     cti = 3'b010;
            drive(m, 1'b1, 1'b1, we, a, wdat + 32'(b), cti);
            t   = 0;
            got = 1'b0;
            while (!got && t < 60) begin
                @(negedge sys_clk);
                got = (m == 0) ? (ifs0_ack | ifs0_err) : (ifs1_ack | ifs1_err);
                t++;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL m%0d_timeout: got no response in 60 cycles, required ack at adr 0x%h", m, a);
            end
            @(posedge sys_clk); #1;
            a = a + 32'd4;
        end
        drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("reset_quiet", 32'({grant, ifm_cyc, ifm_stb, ifs0_ack, ifs1_ack}), 32'd0);
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

        // Simultaneous request after reset: master 0 first, one gap cycle, then master 1.
        fork
            wb_xfer(0, 1, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
            wb_xfer(1, 1, 1'b0, 32'h104, 32'h0, 1'b0, 32'hB0000104);
            begin
                @(posedge sys_clk);
                @(negedge sys_clk); chk("sim_latency", 32'(grant), 32'd0);
                @(negedge sys_clk); chk("sim_first", 32'(grant), 32'(2'b01));
                repeat (3) @(negedge sys_clk);
                chk("sim_gap", 32'({grant, ifm_cyc}), 32'(3'b010));
                @(negedge sys_clk); chk("sim_handover", 32'({grant, ifm_cyc}), 32'(3'b101));
            end
        join

        fork
            wb_xfer(0, 1, 1'b1, 32'h108, 32'h11111111, 1'b0, 32'h0);
            wb_xfer(1, 1, 1'b1, 32'h10C, 32'h22222222, 1'b0, 32'h0);
            begin
                @(posedge sys_clk);
                @(negedge sys_clk); chk("rr2_idle", 32'(grant), 32'd0);
                @(negedge sys_clk); chk("rr2_first", 32'(grant), 32'(2'b01));
            end
        join

        // Single master read with two wait states.
        fork
            wb_xfer(0, 1, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
            begin
                @(posedge sys_clk);
                repeat (2) @(negedge sys_clk);
                chk("single_grant", 32'(grant), 32'(2'b01));
                repeat (4) @(negedge sys_clk);
                chk("single_release", 32'(grant), 32'd0);
            end
        join

        // Master 1 bursts while master 0 waits with cyc high.
        slv_wait = 0;
        fork
            wb_xfer(1, 8, 1'b0, 32'h200, 32'h0, 1'b0, 32'hB0000200);
            wb_xfer(0, 1, 1'b0, 32'h300, 32'h0, 1'b0, 32'hB0000300);
            begin
                int viol;
                viol = 0;
                @(posedge sys_clk);
                repeat (2) @(negedge sys_clk);
                chk("burst_owner", 32'(grant), 32'(2'b10));
                for (int i = 0; i < 100; i++) begin
                    @(negedge sys_clk);
                    if (!ifs1_cyc) break;
                    if (grant != 2'b10 || ifs0_ack) viol++;
                end
                chk("burst_hold", 32'(viol), 32'd0);
                @(negedge sys_clk); chk("burst_next", 32'(grant), 32'(2'b01));
            end
        join

        slv_wait   = 1;
        slv_err_en = 1'b1;
        fork
            wb_xfer(0, 1, 1'b1, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0);
            begin
                int t;
                t = 0;
                @(negedge sys_clk);
                while (!ifm_err && t < 60) begin
                    @(negedge sys_clk);
                    t++;
                end
                chk("err_same_cycle", 32'({ifs1_err, ifs0_err, ifm_err}), 32'(3'b011));
            end
        join
        slv_err_en = 1'b0;

        // Reset while master 1 owns the bus with a request outstanding.
        slv_wait = 20;
        @(posedge sys_clk); #1;
        drive(1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
        repeat (2) @(negedge sys_clk);
        chk("mid_owner", 32'({grant, ifm_stb}), 32'(3'b101));
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mid_reset_drop", 32'({grant, ifm_cyc, ifm_stb}), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        slv_wait = 1;

        fork
            wb_xfer(0, 1, 1'b0, 32'h110, 32'h0, 1'b0, 32'hB0000110);
            wb_xfer(1, 1, 1'b0, 32'h114, 32'h0, 1'b0, 32'hB0000114);
            begin
                @(posedge sys_clk);
                @(negedge sys_clk); chk("restart_idle", 32'(grant), 32'd0);
                @(negedge sys_clk); chk("restart_first", 32'(grant), 32'(2'b01));
            end
        join

        repeat (5) @(negedge sys_clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
